// File: rtl/approx_seq_multiplier.sv
// Iterative shift-add N x N unsigned multiplier with approximate or exact row accumulation and an error-event counter.
// Latency: fixed N+1 cycles from accept to out_valid, independent of operand values.
// Backpressure: one operation in flight; in_ready low in RUN/DONE; result held in DONE until out_ready.
module approx_seq_multiplier #(
  parameter int N   = 8,
  parameter int ECW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             exact_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic [ECW-1:0]   err_count
);

  localparam int W   = 2 * N;
  localparam int STW = (N > 1) ? $clog2(N) : 1;
  localparam int PCW = $clog2(W + 1);
  localparam int SW  = ((ECW > PCW) ? ECW : PCW) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [STW-1:0] LAST_STEP = STW'(N - 1);
  localparam logic [ECW-1:0] ERR_MAX   = '1;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           mode_q, mode_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [ECW-1:0] err_q, err_d;
  logic [STW-1:0] step_q, step_d;

  logic [W-1:0]   pp;
  logic [W-1:0]   x;
  logic [W-1:0]   g_sh;
  logic [W-1:0]   acc_apx;
  logic [W-1:0]   acc_exact;
  logic [W-1:0]   e;
  logic [PCW-1:0] pc;
  logic [SW-1:0]  err_sum;
  logic [ECW-1:0] err_sat;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = acc_q;
  assign err_count = err_q;

  // One partial-product row: approximate sum/error equations, exact sum, and saturating error update.
  always_comb begin
    pp = b_q[step_q] ? (a_q << step_q) : '0;
    x  = acc_q ^ pp;
    // Generate from bit i-1 feeds bit i; the shift drops bit 2N-1's generate.
    g_sh      = (acc_q & pp) << 1;
    acc_apx   = x | g_sh;
    e         = x & g_sh;
    acc_exact = acc_q + pp;
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + PCW'(e[i]);
    end
    err_sum = SW'(err_q) + SW'(pc);
    err_sat = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ECW-1:0];
  end

  // Next-state control: accept in IDLE, N accumulation steps in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    err_d   = err_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = {{N{1'b0}}, a};
          b_d     = b;
          mode_d  = exact_mode;
          acc_d   = '0;
          err_d   = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = mode_q ? acc_exact : acc_apx;
        err_d = mode_q ? err_q : err_sat;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      err_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_approx_seq_multiplier.sv
// Self-checking bench for approx_seq_multiplier: directed cases plus random regression
// against a bit-level behavioural model; a second instance with ECW=3 exercises saturation.
module tb_approx_seq_multiplier;

  localparam int N = 8;
  localparam int W = 2 * N;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic exact_mode;
  logic out_ready;

  logic in_ready8, out_valid8;
  logic [W-1:0] product8;
  logic [7:0] err8;
  logic in_ready3, out_valid3;
  logic [W-1:0] product3;
  logic [2:0] err3;

  int n_cmp = 0;
  int n_bad = 0;
  bit busy = 1'b0;
  bit [W-1:0] exp_prod = '0;
  int exp_err = 0;

  always #5 clk = ~clk;

  approx_seq_multiplier #(.N(N), .ECW(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .exact_mode(exact_mode), .out_valid(out_valid8),
    .out_ready(out_ready), .product(product8), .err_count(err8)
  );

  approx_seq_multiplier #(.N(N), .ECW(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .a(a), .b(b), .exact_mode(exact_mode), .out_valid(out_valid3),
    .out_ready(out_ready), .product(product3), .err_count(err3)
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: add rows LSB first; approximate rows use per-bit sum = x|g(i-1), error = x&g(i-1).
  function automatic void model(input bit [N-1:0] ma, input bit [N-1:0] mb, input bit mexact,
                                input int nsteps, output bit [W-1:0] macc, output int merr);
    bit [W-1:0] pp;
    bit [W-1:0] nxt;
    bit xi;
    bit gp;
    macc = '0;
    merr = 0;
    for (int s = 0; s < nsteps; s++) begin
      pp = mb[s] ? (W'(ma) << s) : '0;
      if (mexact) begin
        macc = macc + pp;
      end else begin
        nxt = '0;
        for (int i = 0; i < W; i++) begin
          xi = macc[i] ^ pp[i];
          gp = 1'b0;
          if (i > 0) gp = macc[i-1] & pp[i-1];
          nxt[i] = xi | gp;
          if (xi && gp) merr++;
        end
        macc = nxt;
      end
    end
  endfunction

  // Per-cycle compare against the bench's expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready8, !busy);
      chk("in_ready_e3", in_ready3, !busy);
      if (out_valid8) begin
        chk("product", product8, exp_prod);
        chk("err_count", err8, exp_err);
        chk("product_e3", product3, exp_prod);
        chk("err_sat_e3", err3, (exp_err > 7) ? 7 : exp_err);
      end
    end
  end

  task automatic run_op(input bit [N-1:0] ta, input bit [N-1:0] tb_, input bit tm, input int stall);
    int wc;
    bit [W-1:0] p;
    int e;
    wc = 0;
    @(negedge clk);
    while (!in_ready8 && wc < 50) begin
      @(negedge clk);
      wc++;
    end
    if (!in_ready8) chk("idle_timeout", 0, 1);
    a = ta;
    b = tb_;
    exact_mode = tm;
    in_valid = 1'b1;
    @(posedge clk);
    model(ta, tb_, tm, N, p, e);
    exp_prod = p;
    exp_err = e;
    busy = 1'b1;
    #1;
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    exact_mode = 1'($urandom);
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      chk("lat_early", out_valid8, 0);
    end
    @(negedge clk);
    chk("lat_valid", out_valid8, 1);
    // A request arriving while the result is pending must not be taken.
    in_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("held_valid", out_valid8, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("valid_drop", out_valid8, 0);
    chk("prod_keep", product8, exp_prod);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [W-1:0] p;
    int e;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    exact_mode = 1'b0;

    // Model pins from hand-worked values.
    model(8'd3, 8'd3, 1'b0, 2, p, e);
    chk("model_3x3_step1_acc", p, 5);
    chk("model_3x3_step1_err", e, 1);
    model(8'd13, 8'd11, 1'b1, N, p, e);
    chk("model_13x11", p, 143);
    model(8'd255, 8'd255, 1'b1, N, p, e);
    chk("model_255x255", p, 65025);
    model(8'd1, 8'd255, 1'b0, N, p, e);
    chk("model_1x255_p", p, 255);
    chk("model_1x255_e", e, 0);

    // Reset values.
    #2;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_product", product8, 0);
    chk("rst_err", err8, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of RUN (step 3).
    @(negedge clk);
    a = 8'd200;
    b = 8'd100;
    exact_mode = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    busy = 1'b1;
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    busy = 1'b0;
    chk("arst_in_ready", in_ready8, 1);
    chk("arst_out_valid", out_valid8, 0);
    chk("arst_product", product8, 0);
    chk("arst_err", err8, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      @(negedge clk);
      chk("no_partial_result", out_valid8, 0);
    end

    // Directed cases with literal result checks.
    run_op(8'd13, 8'd11, 1'b1, 0);
    chk("lit_13x11_p", product8, 143);
    chk("lit_13x11_e", err8, 0);
    run_op(8'd255, 8'd255, 1'b1, 1);
    chk("lit_255x255_p", product8, 65025);
    chk("lit_255x255_e", err8, 0);
    run_op(8'd3, 8'd3, 1'b0, 0);
    chk("lit_3x3_apx_p", product8, 5);
    chk("lit_3x3_apx_e", err8, 1);
    run_op(8'd1, 8'd255, 1'b0, 0);
    chk("lit_1x255_apx_p", product8, 255);
    chk("lit_1x255_apx_e", err8, 0);

    // Zero operands, both modes.
    for (int m = 0; m < 2; m++) begin
      run_op(8'd255, 8'd0, 1'(m), 0);
      chk("lit_zero_b_p", product8, 0);
      chk("lit_zero_b_e", err8, 0);
      run_op(8'd0, 8'd255, 1'(m), 0);
      chk("lit_zero_a_p", product8, 0);
      chk("lit_zero_a_e", err8, 0);
    end

    // Backpressure: 5 stalled cycles in DONE with a competing request.
    run_op(8'd200, 8'd100, 1'b1, 5);
    chk("lit_200x100_p", product8, 20000);
    run_op(8'd255, 8'd255, 1'b0, 5);

    // Random regression.
    for (int k = 0; k < 3000; k++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
